// File: rtl/simd_pkg.sv
// Shared encodings for the packed-SIMD saturation stage: width codes, clamp bytes,
// skid-buffer state type and the element-owner lookup used per lane.
package simd_pkg;

    localparam int LANES = 4;

    localparam logic [1:0] W8   = 2'b00;
    localparam logic [1:0] W16  = 2'b01;
    localparam logic [1:0] W32  = 2'b10;
    localparam logic [1:0] WRSV = 2'b11;

    localparam logic [7:0] SAT_POS_MS = 8'h7F;
    localparam logic [7:0] SAT_NEG_MS = 8'h80;
    localparam logic [7:0] SAT_POS_LO = 8'hFF;
    localparam logic [7:0] SAT_NEG_LO = 8'h00;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b01,
        SKID_FULL  = 2'b10
    } skid_state_t;

    // Lane holding the MS byte (and thus the overflow flag) of the element containing lane.
    function automatic logic [1:0] owner_lane(input logic [1:0] width, input logic [1:0] lane);
        logic [1:0] owner;
        case (width)
            W8:      owner = lane;
            W16:     owner = lane[1] ? 2'd3 : 2'd1;
            default: owner = 2'd3;
        endcase
        return owner;
    endfunction

endpackage

// File: rtl/simd_lane_sat.sv
// Combinational clamp mux for one byte lane: substitutes the saturation byte
// when the lane is enabled and its element overflowed.
module simd_lane_sat
    import simd_pkg::*;
(
    input  logic [7:0] sum_byte,
    input  logic       ovf,
    input  logic       en,
    input  logic       sign,
    input  logic       last,
    output logic [7:0] sat_byte,
    output logic       sat
);

    always_comb begin
        sat      = en & ovf;
        sat_byte = sum_byte;
        if (sat) begin
            if (last) begin
                sat_byte = sign ? SAT_NEG_MS : SAT_POS_MS;
            end else begin
                sat_byte = sign ? SAT_NEG_LO : SAT_POS_LO;
            end
        end
    end

endmodule

// File: rtl/simd_sat_stage.sv
// Registered saturation/output stage with a 2-entry skid buffer and sticky per-lane flags.
// Optional saturation event counter enabled by defining SIMD_SAT_CNT_EN.
module simd_sat_stage
    import simd_pkg::*;
#(
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_sum,
    input  logic [1:0]       in_width,
    input  logic [3:0]       in_overflow,
    input  logic [3:0]       in_sat_enable,
    input  logic [3:0]       in_sat_sign,
    input  logic [3:0]       in_sat_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [3:0]       out_sat,
    output logic [3:0]       status_sat,
    input  logic             status_clr
`ifdef SIMD_SAT_CNT_EN
    ,
    output logic [CNT_W-1:0] sat_count
`endif
);

    logic        width_rsv;
    logic [3:0]  lane_ovf;
    logic [31:0] beat_data;
    logic [3:0]  beat_sat;

    assign width_rsv = (in_width == WRSV);

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_ovf[gi] = in_overflow[owner_lane(in_width, 2'(gi))];

            simd_lane_sat u_lane_sat (
                .sum_byte (in_sum[8*gi +: 8]),
                .ovf      (lane_ovf[gi]),
                .en       (in_sat_enable[gi] & ~width_rsv),
                .sign     (in_sat_sign[gi]),
                .last     (in_sat_last[gi]),
                .sat_byte (beat_data[8*gi +: 8]),
                .sat      (beat_sat[gi])
            );
        end
    endgenerate

    skid_state_t state_reg, state_next;
    logic        in_ready_reg;
    logic [31:0] head_data_reg, tail_data_reg;
    logic [3:0]  head_sat_reg, tail_sat_reg;
    logic [3:0]  status_reg, status_next;
    logic        accept, drain;
    logic        load_head, load_tail, shift_tail;

    assign accept = in_valid & in_ready_reg;
    assign drain  = (state_reg != SKID_EMPTY) & out_ready;

    always_comb begin
        state_next = state_reg;
        load_head  = 1'b0;
        load_tail  = 1'b0;
        shift_tail = 1'b0;
        case (state_reg)
            SKID_EMPTY: begin
                if (accept) begin
                    state_next = SKID_ONE;
                    load_head  = 1'b1;
                end
            end
            SKID_ONE: begin
                if (accept && !drain) begin
                    state_next = SKID_FULL;
                    load_tail  = 1'b1;
                end else if (drain && !accept) begin
                    state_next = SKID_EMPTY;
                end else if (drain && accept) begin
                    load_head = 1'b1;
                end
            end
            SKID_FULL: begin
                if (drain) begin
                    state_next = SKID_ONE;
                    shift_tail = 1'b1;
                end
            end
            default: state_next = SKID_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= SKID_EMPTY;
            in_ready_reg  <= 1'b1;
            head_data_reg <= '0;
            head_sat_reg  <= '0;
            tail_data_reg <= '0;
            tail_sat_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            in_ready_reg <= (state_next != SKID_FULL);
            if (load_head) begin
                head_data_reg <= beat_data;
                head_sat_reg  <= beat_sat;
            end else if (shift_tail) begin
                head_data_reg <= tail_data_reg;
                head_sat_reg  <= tail_sat_reg;
            end
            if (load_tail) begin
                tail_data_reg <= beat_data;
                tail_sat_reg  <= beat_sat;
            end
        end
    end

    // Flags set at accept time; a same-cycle set overrides the clear for that lane.
    always_comb begin
        status_next = status_clr ? 4'b0000 : status_reg;
        if (accept) begin
            status_next = status_next | beat_sat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_reg <= '0;
        end else begin
            status_reg <= status_next;
        end
    end

    assign in_ready   = in_ready_reg;
    assign out_valid  = (state_reg != SKID_EMPTY);
    assign out_data   = head_data_reg;
    assign out_sat    = head_sat_reg;
    assign status_sat = status_reg;

`ifdef SIMD_SAT_CNT_EN
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (accept && (|beat_sat)) begin
            if (status_clr) begin
                cnt_reg <= CNT_W'(1);
            end else if (cnt_reg != {CNT_W{1'b1}}) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end else if (status_clr) begin
            cnt_reg <= '0;
        end
    end

    assign sat_count = cnt_reg;
`endif

endmodule

// File: tb/tb_simd_sat_stage.sv
// Self-checking bench for simd_sat_stage: directed cases, backpressure, reset, random beats.
module tb_simd_sat_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_sum;
    logic [1:0]  in_width;
    logic [3:0]  in_overflow;
    logic [3:0]  in_sat_enable;
    logic [3:0]  in_sat_sign;
    logic [3:0]  in_sat_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_sat;
    logic [3:0]  status_sat;
    logic        status_clr;
`ifdef SIMD_SAT_CNT_EN
    logic [15:0] sat_count;
    logic [15:0] cnt_model;
`endif

    int total = 0;
    int bad   = 0;

    logic [35:0] exp_q[$];
    logic [3:0]  st_model;

    always #5 clk = ~clk;

    simd_sat_stage #(.LANES(4), .CNT_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sum        (in_sum),
        .in_width      (in_width),
        .in_overflow   (in_overflow),
        .in_sat_enable (in_sat_enable),
        .in_sat_sign   (in_sat_sign),
        .in_sat_last   (in_sat_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_sat       (out_sat),
        .status_sat    (status_sat),
        .status_clr    (status_clr)
`ifdef SIMD_SAT_CNT_EN
        ,
        .sat_count     (sat_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: element of 2^width bytes, overflow flag lives in its top lane.
    function automatic logic [35:0] ref_beat(input logic [31:0] sum, input logic [1:0] width,
                                             input logic [3:0] ovf, input logic [3:0] en,
                                             input logic [3:0] sign, input logic [3:0] last);
        logic [31:0] d;
        logic [3:0]  s;
        int          n;
        int          owner;
        d = sum;
        s = 4'b0000;
        if (width != 2'b11) begin
            n = 1 << width;
            for (int i = 0; i < 4; i++) begin
                owner = (i / n) * n + n - 1;
                if (en[i] && ovf[owner]) begin
                    s[i] = 1'b1;
                    if (last[i]) d[8*i +: 8] = sign[i] ? 8'h80 : 8'h7F;
                    else         d[8*i +: 8] = sign[i] ? 8'h00 : 8'hFF;
                end
            end
        end
        return {s, d};
    endfunction

    task automatic set_beat(input logic [31:0] sum, input logic [1:0] width, input logic [3:0] ovf,
                            input logic [3:0] en, input logic [3:0] sign, input logic [3:0] last);
        in_sum        = sum;
        in_width      = width;
        in_overflow   = ovf;
        in_sat_enable = en;
        in_sat_sign   = sign;
        in_sat_last   = last;
    endtask

    // One clock: check handshake/head against the model, advance, check sticky state.
    task automatic tick();
        logic        acc, drn;
        logic [35:0] r;
        acc = in_valid && (exp_q.size() < 2);
        drn = (exp_q.size() != 0) && out_ready;
        chk("in_ready", {31'b0, in_ready}, {31'b0, exp_q.size() < 2});
        chk("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
            chk("out_data", out_data, exp_q[0][31:0]);
            chk("out_sat", {28'b0, out_sat}, {28'b0, exp_q[0][35:32]});
        end
        r = ref_beat(in_sum, in_width, in_overflow, in_sat_enable, in_sat_sign, in_sat_last);
        @(posedge clk);
        if (drn) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(r);
        st_model = (status_clr ? 4'b0000 : st_model) | (acc ? r[35:32] : 4'b0000);
`ifdef SIMD_SAT_CNT_EN
        if (acc && (|r[35:32])) cnt_model = status_clr ? 16'd1 : ((cnt_model == 16'hFFFF) ? cnt_model : cnt_model + 16'd1);
        else if (status_clr) cnt_model = 16'd0;
`endif
        @(negedge clk);
        chk("status_sat", {28'b0, status_sat}, {28'b0, st_model});
`ifdef SIMD_SAT_CNT_EN
        chk("sat_count", {16'b0, sat_count}, {16'b0, cnt_model});
`endif
    endtask

    task automatic one_beat();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic model_reset();
        exp_q.delete();
        st_model = 4'b0000;
`ifdef SIMD_SAT_CNT_EN
        cnt_model = 16'd0;
`endif
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; status_clr = 1'b0;
        set_beat(32'h0, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0);
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_sat", {28'b0, out_sat}, 32'h0);
        chk("rst_status", {28'b0, status_sat}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // 8-bit lanes: lane3 -> 7F, lane2 -> 80
        set_beat(32'h7F80_01FF, 2'b00, 4'b1100, 4'hF, 4'b0100, 4'hF);
        one_beat();
        chk("dir8_status", {28'b0, status_sat}, 32'hC);
        // 16-bit elements
        set_beat(32'h0000_8001, 2'b01, 4'b0010, 4'hF, 4'b0011, 4'b1010);
        one_beat();
        // 32-bit element, clamped then pass-through with enables off
        set_beat(32'h1234_5678, 2'b10, 4'b1000, 4'hF, 4'b0000, 4'b1000);
        one_beat();
        set_beat(32'h1234_5678, 2'b10, 4'b1000, 4'h0, 4'b0000, 4'b1000);
        one_beat();
        // Reserved width passes raw sum
        set_beat(32'hDEAD_BEEF, 2'b11, 4'hF, 4'hF, 4'hF, 4'hF);
        one_beat();
        // Clear coincident with a lane-0 clamp: only lane 0 remains set
        set_beat(32'h0000_0000, 2'b00, 4'b0001, 4'hF, 4'b0000, 4'hF);
        status_clr = 1'b1;
        in_valid = 1'b1;
        tick();
        status_clr = 1'b0;
        in_valid = 1'b0;
        chk("clr_set_status", {28'b0, status_sat}, 32'h1);
        tick();

        // Backpressure: three beats offered, two held, released in order
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_beat(32'h1111_1111 * (k + 1), 2'b00, 4'(k), 4'hF, 4'h0, 4'hF);
            tick();
        end
        chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();

        // Asynchronous reset with the buffer full
        out_ready = 1'b0;
        in_valid = 1'b1;
        set_beat(32'hCAFE_F00D, 2'b01, 4'hF, 4'hF, 4'h0, 4'b1010);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("arst_status", {28'b0, status_sat}, 32'h0);
        model_reset();
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            in_valid   = $urandom_range(0, 3) != 0;
            out_ready  = $urandom_range(0, 2) != 0;
            status_clr = $urandom_range(0, 15) == 0;
            set_beat($urandom, 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
                     4'($urandom), 4'($urandom));
            tick();
        end
        status_clr = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();

`ifdef SIMD_SAT_CNT_EN
        // Counter saturates at all-ones, then clear+increment yields 1
        in_valid = 1'b1;
        set_beat(32'h0, 2'b10, 4'b1000, 4'hF, 4'h0, 4'b1000);
        for (int k = 0; k < 65540; k++) tick();
        chk("cnt_stuck", {16'b0, sat_count}, 32'h0000_FFFF);
        status_clr = 1'b1;
        tick();
        status_clr = 1'b0;
        chk("cnt_clr_inc", {16'b0, sat_count}, 32'd1);
        in_valid = 1'b0;
        repeat (3) tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
